// File: rtl/cbf_pkg.sv
// Shared types and hash helper for the counting Bloom filter.
// The optional statistics block is enabled with the CBF_STATS_EN macro.
package cbf_pkg;

  typedef enum logic [1:0] {
    OP_QUERY  = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_CLEAR  = 2'b11
  } cbf_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_UPDATE = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_RESP   = 3'd4
  } cbf_state_e;

  // Per-hash salts; hash i xors the key with SALT[i] before rotating.
  localparam logic [31:0] SALT [0:7] = '{
    32'h9E37_79B9, 32'h7F4A_7C15, 32'hC2B2_AE35, 32'h27D4_EB2F,
    32'h1656_67B1, 32'hD3A2_646C, 32'hFD70_46C5, 32'hB55A_4F09
  };

  // 32-bit rotate left; only the low five bits of the amount matter.
  function automatic logic [31:0] cbf_rotl(input logic [31:0] x, input int unsigned s);
    logic [4:0] r;
    r = s[4:0];
    // (5'd0 - r) is 32 - r modulo 32, valid because r == 0 is handled apart.
    if (r == 5'd0) return x;
    return (x << r) | (x >> (5'd0 - r));
  endfunction

  // Salted hash i: fold the top hash_w bits onto the bottom hash_w bits.
  function automatic logic [31:0] cbf_hash(input logic [31:0] data, input int unsigned idx,
                                           input int unsigned hash_w);
    logic [31:0] m;
    logic [31:0] mask;
    m    = cbf_rotl(data ^ SALT[idx[2:0]], 5 * idx);
    mask = (32'd1 << hash_w) - 32'd1;
    return (m & mask) ^ ((m >> (32 - hash_w)) & mask);
  endfunction

endpackage

// File: rtl/cbf_counter_array.sv
// FILTER_SIZE x CNT_W counter storage with one combinational read port
// and one synchronous write port sharing a single address.
module cbf_counter_array #(
  parameter int HASH_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [HASH_W-1:0] addr,
  output logic [CNT_W-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_data
);

  localparam int FILTER_SIZE = 1 << HASH_W;

  logic [CNT_W-1:0] cnt [FILTER_SIZE];

  assign rd_data = cnt[addr];

  // Counter storage: cleared by reset, one slot written per cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FILTER_SIZE; i++) cnt[i] <= '0;
    end else if (wr_en) begin
      cnt[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/counting_bloom_filter.sv
// Counting Bloom filter: NUM_HASH salted hashes visited one per cycle over a
// saturating counter array, behind a request/response handshake.
// Handshake: a request transfers on a cycle where req_valid && req_ready, a
// response transfers on a cycle where resp_valid && resp_ready; while valid is
// high and ready is low the offering side holds its payload stable.
// Define CBF_STATS_EN to add the stat_* counters.
module counting_bloom_filter
  import cbf_pkg::*;
#(
  parameter int NUM_HASH = 3,
  parameter int HASH_W   = 8,
  parameter int CNT_W    = 4,
  parameter int ELEM_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [31:0]       req_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_hit,
  output logic              resp_err,
  output logic [ELEM_W-1:0] elem_count,
  output logic              busy
`ifdef CBF_STATS_EN
  ,
  output logic [31:0]       stat_query_cnt,
  output logic [31:0]       stat_hit_cnt,
  output logic [31:0]       stat_sat_cnt
`endif
);

  localparam int                K_W     = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
  localparam logic [K_W-1:0]    K_LAST  = K_W'(NUM_HASH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  cbf_state_e        state, state_nxt;
  cbf_op_e           op_q;
  logic [31:0]       key_q;
  logic [K_W-1:0]    k;
  logic [HASH_W-1:0] clr_addr;
  logic              all_nz, any_sat;

  logic [HASH_W-1:0] hash_k, cnt_addr;
  logic [CNT_W-1:0]  rd_data, wr_data;
  logic              wr_en;
  logic              accept, k_last, clr_last;
  logic              rd_sat, all_nz_now, any_sat_now;

  assign hash_k      = HASH_W'(cbf_hash(key_q, 32'(k), 32'(HASH_W)));
  assign cnt_addr    = (state == ST_CLEAR) ? clr_addr : hash_k;
  assign accept      = req_valid && req_ready;
  assign k_last      = (k == K_LAST);
  assign clr_last    = (clr_addr == '1);
  assign rd_sat      = (rd_data == CNT_MAX);
  assign all_nz_now  = all_nz && (rd_data != '0);
  assign any_sat_now = any_sat || rd_sat;

  cbf_counter_array #(.HASH_W(HASH_W), .CNT_W(CNT_W)) u_array (
    .clk     (clk),
    .rstn    (rstn),
    .addr    (cnt_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_data (wr_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (accept) state_nxt = (cbf_op_e'(req_op) == OP_CLEAR) ? ST_CLEAR : ST_CHECK;
      ST_CHECK:  if (k_last) begin
                   if (op_q == OP_INSERT || (op_q == OP_DELETE && all_nz_now)) state_nxt = ST_UPDATE;
                   else state_nxt = ST_RESP;
                 end
      ST_UPDATE: if (k_last) state_nxt = ST_RESP;
      ST_CLEAR:  if (clr_last) state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs and counter write port
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    busy       = (state != ST_IDLE);
    wr_en      = 1'b0;
    wr_data    = '0;
    if (state == ST_UPDATE) begin
      wr_en = 1'b1;
      // Saturated counters are sticky; a delete never takes a slot below zero
      // even when two hashes of the key land on the same slot.
      if (rd_sat)                wr_data = CNT_MAX;
      else if (op_q == OP_INSERT) wr_data = rd_data + CNT_W'(1);
      else if (rd_data != '0)    wr_data = rd_data - CNT_W'(1);
      else                       wr_data = '0;
    end else if (state == ST_CLEAR) begin
      wr_en = 1'b1;
    end
  end

  // Request latch, hash/slot indices, check accumulators, response flags, element count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_q       <= OP_QUERY;
      key_q      <= '0;
      k          <= '0;
      clr_addr   <= '0;
      all_nz     <= 1'b1;
      any_sat    <= 1'b0;
      resp_hit   <= 1'b0;
      resp_err   <= 1'b0;
      elem_count <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          op_q     <= cbf_op_e'(req_op);
          key_q    <= req_data;
          k        <= '0;
          clr_addr <= '0;
          all_nz   <= 1'b1;
          any_sat  <= 1'b0;
        end
        ST_CHECK: begin
          all_nz  <= all_nz_now;
          any_sat <= any_sat_now;
          if (k_last) begin
            k        <= '0;
            resp_hit <= all_nz_now;
            resp_err <= (op_q == OP_INSERT) ? any_sat_now :
                        (op_q == OP_DELETE) ? !all_nz_now : 1'b0;
          end else begin
            k <= k + K_W'(1);
          end
        end
        ST_UPDATE: begin
          if (k_last) begin
            k <= '0;
            if (op_q == OP_INSERT) begin
              if (elem_count != '1) elem_count <= elem_count + ELEM_W'(1);
            end else if (elem_count != '0) begin
              elem_count <= elem_count - ELEM_W'(1);
            end
          end else begin
            k <= k + K_W'(1);
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + HASH_W'(1);
          if (clr_last) begin
            elem_count <= '0;
            resp_hit   <= 1'b0;
            resp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CBF_STATS_EN
  // Wrapping statistics; a clear op wipes them along with the array
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_query_cnt <= '0;
      stat_hit_cnt   <= '0;
      stat_sat_cnt   <= '0;
    end else if (state == ST_CLEAR && clr_last) begin
      stat_query_cnt <= '0;
      stat_hit_cnt   <= '0;
      stat_sat_cnt   <= '0;
    end else begin
      if (state == ST_CHECK && k_last && op_q == OP_QUERY) begin
        stat_query_cnt <= stat_query_cnt + 32'd1;
        if (all_nz_now) stat_hit_cnt <= stat_hit_cnt + 32'd1;
      end
      if (state == ST_UPDATE && op_q == OP_INSERT && rd_sat)
        stat_sat_cnt <= stat_sat_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_counting_bloom_filter.sv
// Bench for counting_bloom_filter (default parameters). Build with
// CBF_STATS_EN defined to also exercise the statistics outputs.
module tb_counting_bloom_filter;
  import cbf_pkg::*;

  localparam int NH   = 3;
  localparam int HW   = 8;
  localparam int FS   = 256;
  localparam int MAXC = 15;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_hit, resp_err, busy;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic [15:0] elem_count;
`ifdef CBF_STATS_EN
  logic [31:0] stat_query_cnt, stat_hit_cnt, stat_sat_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state: plain per-slot counts plus element tally
  int mcnt [FS];
  int melem;
  int mq, mh, ms;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
    bit          hit;
    bit          err;
    int          lat;
    int          elem;
  } vec_t;

  vec_t vecs [10];
  logic [31:0] keys [8];

  counting_bloom_filter #(.NUM_HASH(NH), .HASH_W(HW), .CNT_W(4), .ELEM_W(16)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_hit   (resp_hit),
    .resp_err   (resp_err),
    .elem_count (elem_count),
    .busy       (busy)
`ifdef CBF_STATS_EN
    ,
    .stat_query_cnt (stat_query_cnt),
    .stat_hit_cnt   (stat_hit_cnt),
    .stat_sat_cnt   (stat_sat_cnt)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Slot index of hash i: rotate via a doubled word, fold top byte onto bottom byte
  function automatic int model_hash(input logic [31:0] key, input int i);
    logic [63:0] d;
    logic [31:0] m;
    int s;
    s = (5 * i) % 32;
    d = {key ^ SALT[i], key ^ SALT[i]};
    m = 32'(d >> (32 - s));
    return int'(m[7:0] ^ m[31:24]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < FS; i++) mcnt[i] = 0;
    melem = 0; mq = 0; mh = 0; ms = 0;
  endtask

  task automatic model_op(input logic [1:0] op, input logic [31:0] key,
                          output bit hit, output bit err, output int lat, output int elem);
    int h [NH];
    bit all_nz, any_sat;
    all_nz = 1; any_sat = 0;
    for (int i = 0; i < NH; i++) begin
      h[i] = model_hash(key, i);
      if (mcnt[h[i]] == 0) all_nz = 0;
      if (mcnt[h[i]] == MAXC) any_sat = 1;
    end
    hit = all_nz; err = 0; lat = NH + 1;
    case (op)
      2'b00: begin
        mq++;
        if (all_nz) mh++;
      end
      2'b01: begin
        for (int i = 0; i < NH; i++) begin
          if (mcnt[h[i]] == MAXC) ms++;
          else mcnt[h[i]]++;
        end
        err = any_sat;
        lat = 2 * NH + 1;
        if (melem < 65535) melem++;
      end
      2'b10: begin
        err = !all_nz;
        if (all_nz) begin
          for (int i = 0; i < NH; i++)
            if (mcnt[h[i]] != MAXC && mcnt[h[i]] > 0) mcnt[h[i]]--;
          if (melem > 0) melem--;
          lat = 2 * NH + 1;
        end
      end
      default: begin
        model_reset();
        hit = 0;
        lat = FS + 1;
      end
    endcase
    elem = melem;
  endtask

  // Driver: issue one op, hold resp_ready low for 'hold' cycles, check the response
  task automatic do_op(input logic [1:0] op, input logic [31:0] key, input int hold,
                       input bit exp_hit, input bit exp_err, input int exp_lat, input int exp_elem,
                       input string tag);
    int guard;
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_data = key;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'($urandom_range(3, 0));
    req_data  = $urandom;
    while (!resp_valid && lat < 2000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!resp_valid) begin
      check({tag, "_resp_timeout"}, 32'(resp_valid), 32'd1);
      return;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_hit"}, 32'(resp_hit), 32'(exp_hit));
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, "_elem"}, 32'(elem_count), 32'(exp_elem));
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_hit"}, 32'(resp_hit), 32'(exp_hit));
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_idle_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic model_do(input logic [1:0] op, input logic [31:0] key, input int hold, input string tag);
    bit h, e;
    int l, el;
    model_op(op, key, h, e, l, el);
    do_op(op, key, hold, h, e, l, el, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  initial begin
    bit h, e;
    int l, el, r;
    logic [1:0] op;
    logic [31:0] key;

    rstn = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_op = 2'b00; req_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_elem", 32'(elem_count), 32'd0);
    check("rst_hit", 32'(resp_hit), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // Directed table from a clean filter
    vecs[0] = '{2'b00, 32'h0000_1234, 1'b0, 1'b0, 4, 0};
    vecs[1] = '{2'b01, 32'hDEAD_BEEF, 1'b0, 1'b0, 7, 1};
    vecs[2] = '{2'b00, 32'hDEAD_BEEF, 1'b1, 1'b0, 4, 1};
    vecs[3] = '{2'b01, 32'hDEAD_BEEF, 1'b1, 1'b0, 7, 2};
    vecs[4] = '{2'b10, 32'hDEAD_BEEF, 1'b1, 1'b0, 7, 1};
    vecs[5] = '{2'b00, 32'hDEAD_BEEF, 1'b1, 1'b0, 4, 1};
    vecs[6] = '{2'b10, 32'hDEAD_BEEF, 1'b1, 1'b0, 7, 0};
    vecs[7] = '{2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0, 4, 0};
    vecs[8] = '{2'b10, 32'hDEAD_BEEF, 1'b0, 1'b1, 4, 0};
    vecs[9] = '{2'b00, 32'hDEAD_BEEF, 1'b0, 1'b0, 4, 0};
    for (int i = 0; i < 10; i++)
      do_op(vecs[i].op, vecs[i].key, 0, vecs[i].hit, vecs[i].err, vecs[i].lat, vecs[i].elem,
            $sformatf("vec%0d", i));

    // Saturation: 16th insert reports err, then counters stay pinned at max
    do_reset();
    for (int i = 0; i < 16; i++)
      do_op(2'b01, 32'h0000_00AA, 0, i > 0, i == 15, 7, i + 1, $sformatf("sat_ins%0d", i));
    for (int i = 0; i < 16; i++)
      do_op(2'b10, 32'h0000_00AA, 0, 1'b1, 1'b0, 7, 15 - i, $sformatf("sat_del%0d", i));
    do_op(2'b00, 32'h0000_00AA, 0, 1'b1, 1'b0, 4, 0, "sat_query");

    // Clear after three inserts
    do_reset();
    model_do(2'b01, 32'h1111_0001, 0, "clr_ins0");
    model_do(2'b01, 32'h2222_0002, 0, "clr_ins1");
    model_do(2'b01, 32'h3333_0003, 0, "clr_ins2");
    model_op(2'b11, 32'h0, h, e, l, el);
    do_op(2'b11, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 257, 0, "clr");
    do_op(2'b00, 32'h1111_0001, 0, 1'b0, 1'b0, 4, 0, "clr_q0");
    do_op(2'b00, 32'h2222_0002, 0, 1'b0, 1'b0, 4, 0, "clr_q1");
    do_op(2'b00, 32'h3333_0003, 0, 1'b0, 1'b0, 4, 0, "clr_q2");
    model_op(2'b00, 32'h1111_0001, h, e, l, el);
    model_op(2'b00, 32'h2222_0002, h, e, l, el);
    model_op(2'b00, 32'h3333_0003, h, e, l, el);

    // Response back-pressure: flags hold while resp_ready stays low
    model_do(2'b01, 32'h5555_AAAA, 0, "bp_ins");
    model_op(2'b00, 32'h5555_AAAA, h, e, l, el);
    do_op(2'b00, 32'h5555_AAAA, 10, 1'b1, 1'b0, 4, 1, "bp_query");

    // Reset in the middle of UPDATE wipes counters and discards the op
    do_reset();
    do_op(2'b01, 32'h0BAD_F00D, 0, 1'b0, 1'b0, 7, 1, "mid_ins");
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_data = 32'h0BAD_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("mid_busy_rst", 32'(busy), 32'd0);
    check("mid_elem_rst", 32'(elem_count), 32'd0);
    check("mid_valid_rst", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    do_op(2'b00, 32'h0BAD_F00D, 0, 1'b0, 1'b0, 4, 0, "mid_query");

    // Randomized ops against the reference model
    do_reset();
    for (int i = 0; i < 8; i++) keys[i] = $urandom;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(99, 0);
      op = (r < 35) ? 2'b00 : (r < 70) ? 2'b01 : (r < 96) ? 2'b10 : 2'b11;
      key = ($urandom_range(9, 0) == 0) ? $urandom : keys[$urandom_range(7, 0)];
      model_do(op, key, $urandom_range(2, 0), $sformatf("rnd%0d", i));
    end
`ifdef CBF_STATS_EN
    check("stat_query", stat_query_cnt, 32'(mq));
    check("stat_hit", stat_hit_cnt, 32'(mh));
    check("stat_sat", stat_sat_cnt, 32'(ms));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
